operand_select_pipe: RTL and testbench
======================================

# operand_select_pipe

Parametrised, pipelined successor to the processor's 2:1 source-2 operand multiplexer. It selects one of NSRC operand sources, such as register-file data, the extended immediate, or EX/MEM forwarding paths, with a binary select. The selected operand is registered behind a valid/ready handshake with a two-entry skid buffer, so the operand-fetch to ALU boundary sustains one operand per cycle under back-pressure. It also reports illegal selects and counts back-pressure cycles for performance debug.

## Interface
Clocking: one clock, `clk`; reset `rst` is asynchronous and active-high.

Parameters:
- WIDTH, 16, operand width in bits
- NSRC, 4, number of selectable sources (2..16)
- SELW, $clog2(NSRC) (min 1), select width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  source bundle and select are valid
- in_ready  out  1  block can accept this cycle
- sel  in  SELW  source index; source k lives at src_data[k*WIDTH +: WIDTH]
- src_data  in  NSRC*WIDTH  flattened sources; index 0 = register data, 1 = extended immediate
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts
- out_data  out  WIDTH  selected operand
- out_sel_err  out  1  accompanies out_data; sel was >= NSRC (see Configuration)
- stall_cnt  out  16  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Accept: `in_valid && in_ready`. Drain: `out_valid && out_ready`.
- Selection happens at accept time. The chosen word is captured together with its error bit. Sources are not sampled later.
- `sel >= NSRC` captures out_data = 0.
- Storage is an output register (OR) plus a skid register (SK). The FSM has three states:
  - EMPTY: out_valid = 0. Accept → ONE, with OR loaded.
  - ONE: OR valid.
    - Accept and drain together → ONE, OR reloaded with the new word.
    - Drain only → EMPTY.
    - Accept only → TWO, with SK loaded.
  - TWO: OR and SK valid. Drain → ONE, with OR ← SK. No accept is possible in this state.
- `in_ready = (state != TWO)`. This is a registered-state decode, so there is no combinational path from out_ready to in_ready.
- Data order is strictly FIFO. No word is dropped or duplicated.
- stall_cnt increments each cycle with out_valid=1 and out_ready=0. It saturates at 16'hFFFF and is cleared only by rst.

## Timing
- Latency is 1 cycle: a word accepted at edge N is on out_data with out_valid=1 after edge N.
- Throughput is 1 word/cycle while out_ready stays high.
- out_valid, out_data and out_sel_err hold stable while out_valid=1 and out_ready=0.
- Reset values: state EMPTY, out_valid 0, out_data 0, out_sel_err 0, stall_cnt 0, in_ready 1, SK contents 0.
- Reset mid-operation: all held words are discarded immediately, asynchronously. The first accept after rst deasserts behaves as from EMPTY.
- Behaviour when out_ready is asserted while out_valid=0: no effect.
- Behaviour when in_valid is asserted while in_ready=0: the word is not captured, and the source must hold it.
- NSRC not a power of two: any sel codes at or above NSRC are illegal.

## Configuration
- Macro `OPSEL_SEL_ERR_EN`.
- Defined: illegal sel captures out_data=0 with out_sel_err=1. The error bit travels through OR/SK with its word.
- Undefined: illegal sel captures out_data=0. out_sel_err is tied to 0, and no error storage is built.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then stream sel=0,1,2,3 with sources 16'h1111/2222/3333/4444 and out_ready=1 → out_data 1111, 2222, 3333, 4444 on consecutive cycles, 1-cycle latency, stall_cnt=0.
- Hold out_ready=0, then offer 3 words (A, B, C) → A, B accepted; in_ready drops to 0 after B; C is held. Release out_ready → A, B, C drained in order; stall_cnt equals the number of stalled cycles.
- With NSRC=3 and OPSEL_SEL_ERR_EN defined, sel=3 → out_data=0, out_sel_err=1; next legal word has out_sel_err=0. Without the macro → out_sel_err stays 0.
- Assert rst asynchronously in state TWO → out_valid, stall_cnt and out_data drop to 0 immediately and in_ready=1; the first post-reset word is presented alone.
- Hold out_ready=0 for 70000 cycles with a word pending → stall_cnt saturates at 16'hFFFF and does not wrap.
- In ONE, accept and drain in the same cycle repeatedly with random out_ready → scoreboard shows no loss or duplication over 10000 random words.

Source files
------------

// File: rtl/operand_select_pipe.sv
`timescale 1ns/1ps
// operand_select_pipe
//
// Pipelined N:1 source-2 operand multiplexer for the operand-fetch to ALU
// boundary. A binary select picks one of NSRC sources at accept time. The
// chosen word is held in an output register (OR) backed by a skid register
// (SK), so the stage sustains one operand per cycle under back-pressure.
//
// Optional feature (macro OPSEL_SEL_ERR_EN):
//   defined   - an illegal select (sel >= NSRC) raises out_sel_err alongside
//               its zeroed word; the error bit travels through OR/SK.
//   undefined - out_sel_err is tied to 0 and no error storage exists.
//   Both builds capture out_data = 0 for an illegal select.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   in_valid     source bundle and select are valid
//   in_ready     stage can accept this cycle (decoded from registered state)
//   sel          source index; source k is src_data[k*WIDTH +: WIDTH]
//   src_data     flattened sources (0 = register data, 1 = extended imm)
//   out_valid    out_data holds a word
//   out_ready    consumer accepts out_data this cycle
//   out_data     selected operand
//   out_sel_err  the word in out_data came from an illegal select
//   stall_cnt    saturating count of cycles with out_valid=1, out_ready=0
//   fsm_state    current FSM state (0 EMPTY, 1 ONE, 2 TWO) for debug
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and once raised, valid and its
// data hold until the transfer completes.

module operand_select_pipe #(
    parameter int WIDTH = 16,
    parameter int NSRC  = 4,
    parameter int SELW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELW-1:0]       sel,
    input  logic [NSRC*WIDTH-1:0] src_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_sel_err,
    output logic [15:0]           stall_cnt,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sk_data;
    logic [WIDTH-1:0] sel_word;
    logic             sel_bad;
    logic             accept;
    logic             drain;
    logic             or_load_new;
    logic             or_load_sk;
    logic             sk_load;

    // Source selection. Any code without a matching source (including the
    // unused codes when NSRC is not a power of two) yields a zero word.
    always_comb begin
        sel_word = '0;
        sel_bad  = 1'b1;
        for (int k = 0; k < NSRC; k++) begin
            if (sel == SELW'(k)) begin
                sel_word = src_data[k*WIDTH +: WIDTH];
                sel_bad  = 1'b0;
            end
        end
    end

    assign in_ready  = (state != ST_TWO);
    assign out_valid = (state != ST_EMPTY);
    assign fsm_state = state;
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    // Register load enables, shared by the data path and the error bits so
    // a word and its error flag can never drift apart.
    always_comb begin
        or_load_new = accept && ((state == ST_EMPTY) || ((state == ST_ONE) && drain));
        sk_load     = accept && (state == ST_ONE) && !drain;
        or_load_sk  = drain && (state == ST_TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_EMPTY;
            out_data <= '0;
            sk_data  <= '0;
        end else begin
            if (or_load_new) out_data <= sel_word;
            if (or_load_sk)  out_data <= sk_data;
            if (sk_load)     sk_data  <= sel_word;
            case (state)
                ST_EMPTY: if (accept) state <= ST_ONE;
                ST_ONE: begin
                    if (drain && !accept)      state <= ST_EMPTY;
                    else if (accept && !drain) state <= ST_TWO;
                end
                ST_TWO:   if (drain) state <= ST_ONE;
                default:  state <= ST_EMPTY;
            endcase
        end
    end

    // Back-pressure counter: sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

`ifdef OPSEL_SEL_ERR_EN
    logic sk_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sel_err <= 1'b0;
            sk_err      <= 1'b0;
        end else begin
            if (or_load_new) out_sel_err <= sel_bad;
            if (or_load_sk)  out_sel_err <= sk_err;
            if (sk_load)     sk_err      <= sel_bad;
        end
    end
`else
    assign out_sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_operand_select_pipe.sv
`timescale 1ns/1ps
// Bench for operand_select_pipe: a 4-source instance drives the streaming,
// back-pressure, reset and saturation scenarios through a scoreboard, and a
// 3-source instance exercises the illegal-select path.

module tb_operand_select_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

`ifdef OPSEL_SEL_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    // ---------------- 4-source DUT ----------------
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  sel;
    logic [63:0] src_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sel_err;
    logic [15:0] stall_cnt;
    logic [1:0]  fsm_state;

    operand_select_pipe #(.WIDTH(16), .NSRC(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel        (sel),
        .src_data   (src_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sel_err(out_sel_err),
        .stall_cnt  (stall_cnt),
        .fsm_state  (fsm_state)
    );

    // ---------------- 3-source DUT (illegal select) ----------------
    logic        in_valid3;
    logic        in_ready3;
    logic [1:0]  sel3;
    logic [47:0] src3;
    logic        out_valid3;
    logic        out_ready3;
    logic [15:0] out_data3;
    logic        out_sel_err3;
    logic [15:0] stall_cnt3;
    logic [1:0]  fsm_state3;

    operand_select_pipe #(.WIDTH(16), .NSRC(3)) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid3),
        .in_ready   (in_ready3),
        .sel        (sel3),
        .src_data   (src3),
        .out_valid  (out_valid3),
        .out_ready  (out_ready3),
        .out_data   (out_data3),
        .out_sel_err(out_sel_err3),
        .stall_cnt  (stall_cnt3),
        .fsm_state  (fsm_state3)
    );

    // ---------------- scoreboard ----------------
    logic [16:0] exp_q[$];   // {err, data}
    logic [16:0] exp_word;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected word for every drain the DUT performs.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got %h, expected no word (t=%0t)", out_data, $time);
            end else begin
                exp_word = exp_q.pop_front();
                check("sb_data", 32'(out_data), 32'(exp_word[15:0]));
                check("sb_err", 32'(out_sel_err), 32'(exp_word[16]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Offer one word; push its expected value once the DUT is seen ready.
    task automatic send(input logic [1:0] s, input logic [63:0] src, input logic [16:0] exp);
        int n;
        n = 0;
        sel      = s;
        src_data = src;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0, expected 1 within 100 cycles");
        end else begin
            exp_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] t1_exp[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [63:0] src1 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    logic [63:0] src2 = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    logic [1:0]  rs;
    logic [63:0] rsrc;
    logic        rand_done;

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        sel        = '0;
        src_data   = '0;
        out_ready  = 1'b0;
        in_valid3  = 1'b0;
        sel3       = '0;
        src3       = '0;
        out_ready3 = 1'b1;
        rand_done  = 1'b0;

        // Reset state
        #3;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_stall_cnt", 32'(stall_cnt), 0);
        check("rst_sel_err", 32'(out_sel_err), 0);
        check("rst_state", 32'(fsm_state), 0);
        cycle();
        rst = 1'b0;

        // Stream four sources with the consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(2'(i), src1, {1'b0, t1_exp[i]});
            check("stream_valid", 32'(out_valid), 1);
            check("stream_data", 32'(out_data), 32'(t1_exp[i]));
        end
        cycle();
        check("stream_empty", 32'(out_valid), 0);
        check("stream_stall", 32'(stall_cnt), 0);

        // Back-pressure: A and B fill OR/SK, C waits
        out_ready = 1'b0;
        send(2'd0, src2, {1'b0, 16'hAAAA});
        send(2'd1, src2, {1'b0, 16'hBBBB});
        check("full_in_ready", 32'(in_ready), 0);
        check("full_state", 32'(fsm_state), 2);
        sel      = 2'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("hold_in_ready", 32'(in_ready), 0);
            check("hold_data", 32'(out_data), 32'hAAAA);
        end
        check("hold_stall", 32'(stall_cnt), 4);
        out_ready = 1'b1;
        send(2'd3, src2, {1'b0, 16'hDDDD});
        cycle();
        check("bp_drained", 32'(out_valid), 0);
        check("bp_stall", 32'(stall_cnt), 4);
        check("bp_queue", 32'(exp_q.size()), 0);

        // Illegal select on the 3-source instance
        src3      = {16'h3333, 16'h2222, 16'h1111};
        sel3      = 2'd3;
        in_valid3 = 1'b1;
        cycle();
        check("bad_valid", 32'(out_valid3), 1);
        check("bad_data", 32'(out_data3), 0);
        check("bad_err", 32'(out_sel_err3), 32'(EXP_ERR));
        sel3 = 2'd2;
        cycle();
        check("legal_data", 32'(out_data3), 32'h3333);
        check("legal_err", 32'(out_sel_err3), 0);
        in_valid3 = 1'b0;
        cycle();
        check("bad_empty", 32'(out_valid3), 0);

        // Asynchronous reset while full
        out_ready = 1'b0;
        send(2'd2, src2, {1'b0, 16'hCCCC});
        send(2'd1, src2, {1'b0, 16'hBBBB});
        check("pre_rst_state", 32'(fsm_state), 2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_stall", 32'(stall_cnt), 0);
        check("arst_data", 32'(out_data), 0);
        check("arst_in_ready", 32'(in_ready), 1);
        exp_q.delete();
        cycle();
        rst       = 1'b0;
        out_ready = 1'b1;
        send(2'd3, src2, {1'b0, 16'hDDDD});
        check("post_rst_data", 32'(out_data), 32'hDDDD);
        cycle();
        check("post_rst_alone", 32'(out_valid), 0);
        check("post_rst_queue", 32'(exp_q.size()), 0);

        // Stall counter saturation
        out_ready = 1'b0;
        send(2'd1, src2, {1'b0, 16'hBBBB});
        repeat (65600) cycle();
        check("sat_stall", 32'(stall_cnt), 32'hFFFF);
        check("sat_valid", 32'(out_valid), 1);
        check("sat_data", 32'(out_data), 32'hBBBB);
        out_ready = 1'b1;
        cycle();
        cycle();
        check("sat_hold", 32'(stall_cnt), 32'hFFFF);
        check("sat_drained", 32'(out_valid), 0);

        // Random words with random back-pressure
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    rs   = 2'($urandom_range(0, 3));
                    rsrc = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
                    send(rs, rsrc, {1'b0, rsrc[int'(rs)*16 +: 16]});
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    cycle();
                end
            end
        join
        out_ready = 1'b1;
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) cycle();
        check("rand_queue", 32'(exp_q.size()), 0);
        cycle();
        check("rand_empty", 32'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Time limit well above the expected run length
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "time limit reached");
    end

endmodule
